alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Parametrised execute stage that replaces the fixed 16-bit ALU stage. It takes decoded operands and side-band control from decode, selects register or immediate operand B, and computes single-cycle ALU ops plus an iterative multi-cycle multiply. It drives memory/write-back through a two-register valid/ready pipeline with stall, flush and a sticky overflow flag.

## Interface
- DATA_W, 16, operand/result width (≥8, power of 2)
- IMM_W, 9, immediate width (< DATA_W)
- RADDR_W, 3, destination register address width
- IMM_SIGNED, 0, 0 = zero-extend immediate, 1 = sign-extend
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid / in_ready  in/out  1  decode handshake; transfer when both high
- reg_a, reg_b  in  DATA_W  operands
- cop  in  4  opcode
- imm  in  IMM_W  immediate
- data_reg  in  DATA_W  store data, passed through
- ldst_en  in  2  load/store enable, passed through
- dest_addr  in  RADDR_W  passed through
- we  in  1  write enable, passed through
- bp  in  2  bypass control, passed through
- flush  in  1  synchronous kill of all in-flight entries
- clr_ovf  in  1  clears sticky overflow
- out_valid / out_ready  out/in  1  downstream handshake
- result  out  DATA_W  ALU result
- ovf  out  1  overflow of the op in the output register
- ovf_sticky  out  1  OR of every ovf delivered since reset/clr_ovf
- data_reg_o, ldst_en_o, dest_addr_o, we_o, bp_o  out  matching  side-band aligned with result

## Operation
- Two stages: operand register (op_valid), output register (out_valid). Side-band travels with its op.
- Operand B = extended imm for MOV, LD, ST; reg_b otherwise.
- Opcodes: ADD 0000 A+B; SUB 0001 A−B; AND 0010; MOV 0011 result=B; OR 0100; XOR 0101; LD 0110 / ST 0111 A+B (address); SHL 1000 A<<B[log2 DATA_W−1:0]; SHR 1001 logical; MUL 1010 low DATA_W bits of unsigned A·B; others result 0, ovf 0.
- ovf: ADD/SUB/LD/ST signed two's-complement overflow; MUL any nonzero bit above DATA_W; else 0.
- MUL FSM: IDLE → MUL_RUN (counter 0..DATA_W−1, one shift-add bit per cycle) → MUL_DONE (result ready, holds until output register loads) → IDLE.
- Output register loads when op_valid, result ready, and (!out_valid or out_ready). in_ready = !op_valid or operand register advances this cycle.
- flush: op_valid, out_valid ← 0, FSM → IDLE, counter ← 0; input presented the same cycle is not accepted (in_ready forced 0). flush has priority over all.
- clr_ovf clears ovf_sticky; if an ovf=1 op is delivered the same cycle, sticky ends 1.

## Timing
- Reset values: in_ready 1, out_valid 0, result 0, ovf 0, ovf_sticky 0, all side-band outputs 0, FSM IDLE.
- Single-cycle op accepted at edge T: out_valid=1 after edge T+1. Back-to-back throughput 1/cycle with out_ready held high.
- MUL accepted at edge T: out_valid after edge T+DATA_W+1; in_ready 0 while MUL occupies operand register.
- out_ready low with out_valid high: output and side-band hold stable; operand register stalls once its result is ready; in_ready drops.
- Reset asserted mid-MUL: immediate return to reset values; no partial result delivered.
- ovf_sticky updates on the edge the op is delivered (out_valid && out_ready).

## Structure
- Package alu_pkg: opcode localparams (OP_ADD … OP_MUL), mul FSM state enum, sign/zero-extend function.
- Sub-module alu_mul_iter: start/busy/done shift-add multiplier, DATA_W-parameterised, returns 2·DATA_W product.
- Combinational single-cycle ALU and B-select live in the top.

## Test plan
- Reset then ADD 0x7FFF+0x0001 (DATA_W=16) → result 0x8000, ovf 1, ovf_sticky 1, out_valid one cycle after acceptance edge.
- MOV imm=0x1FF, IMM_SIGNED=0 → 0x01FF; IMM_SIGNED=1 → 0xFFFF; LD reg_a=0x0100 imm=0x004 → 0x0104, ldst_en/dest_addr unchanged.
- MUL 0x0100·0x0100 → result 0x0000, ovf 1, out_valid exactly 17 edges after acceptance; in_ready 0 throughout.
- Stream of 8 ADDs with out_ready toggling 1,0,1,0 → all 8 results in order, none dropped/duplicated, outputs stable while stalled.
- flush during MUL_RUN cycle 5 → out_valid stays 0, next ADD 2+3 returns 5 with correct latency.
- reset pulse mid-stream → all outputs at reset values asynchronously; first op after release behaves as from reset.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, multiplier FSM states and immediate extension for the execute stage
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_MOV = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_SHR = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hA;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Bits at and above w are filled with bit w-1 (sign) or zero.
    function automatic logic [63:0] extend_imm(input logic [63:0] v, input int w, input logic sgn);
        logic [63:0] r;
        r = v;
        for (int i = 0; i < 64; i++) begin
            if (i >= w) r[i] = sgn ? v[w-1] : 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one multiplier bit per cycle
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  ack,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W);

    mul_state_e             state;
    logic [CNT_W-1:0]       cnt;
    logic [2*DATA_W-1:0]    mcand;
    logic [DATA_W-1:0]      mplier;
    logic [2*DATA_W-1:0]    acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (clear) begin
            state <= MUL_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{DATA_W{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                        state  <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= MUL_DONE;
                end
                MUL_DONE: begin
                    // A new multiply may be accepted on the same edge the finished one retires.
                    if (ack && start) begin
                        acc    <= '0;
                        mcand  <= {{DATA_W{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                        state  <= MUL_RUN;
                    end else if (ack) begin
                        state <= MUL_IDLE;
                    end
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

    assign busy    = (state == MUL_RUN);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - two-register execute stage: operand select, single-cycle ALU, iterative multiply
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int IMM_W      = 9,
    parameter int RADDR_W    = 3,
    parameter int IMM_SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  reg_a,
    input  logic [DATA_W-1:0]  reg_b,
    input  logic [3:0]         cop,
    input  logic [IMM_W-1:0]   imm,
    input  logic [DATA_W-1:0]  data_reg,
    input  logic [1:0]         ldst_en,
    input  logic [RADDR_W-1:0] dest_addr,
    input  logic               we,
    input  logic [1:0]         bp,
    input  logic               flush,
    input  logic               clr_ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               ovf,
    output logic               ovf_sticky,
    output logic [DATA_W-1:0]  data_reg_o,
    output logic [1:0]         ldst_en_o,
    output logic [RADDR_W-1:0] dest_addr_o,
    output logic               we_o,
    output logic [1:0]         bp_o
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    logic [DATA_W-1:0]  b_sel;
    logic               accept, out_load, res_ready;
    logic               op_valid, op_we;
    logic [DATA_W-1:0]  op_a, op_b, op_data;
    logic [3:0]         op_cop;
    logic [1:0]         op_ldst, op_bp;
    logic [RADDR_W-1:0] op_dest;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_ovf;
    logic               mul_busy, mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign b_sel = (cop == OP_MOV || cop == OP_LD || cop == OP_ST)
                 ? DATA_W'(extend_imm(64'(imm), IMM_W, IMM_SIGNED != 0))
                 : reg_b;

    assign res_ready = (op_cop != OP_MUL) || (mul_done && !mul_busy);
    assign out_load  = op_valid && res_ready && (!out_valid || out_ready) && !flush;
    assign in_ready  = !flush && (!op_valid || out_load);
    assign accept    = in_valid && in_ready;

    alu_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .start   (accept && cop == OP_MUL),
        .ack     (out_load),
        .a       (reg_a),
        .b       (b_sel),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_cop)
            OP_ADD, OP_LD, OP_ST: begin
                alu_res = op_a + op_b;
                alu_ovf = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_MOV: alu_res = op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: alu_res = op_a << op_b[SH_W-1:0];
            OP_SHR: alu_res = op_a >> op_b[SH_W-1:0];
            OP_MUL: begin
                alu_res = mul_product[DATA_W-1:0];
                alu_ovf = |mul_product[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_cop   <= '0;
            op_data  <= '0;
            op_ldst  <= '0;
            op_dest  <= '0;
            op_we    <= 1'b0;
            op_bp    <= '0;
        end else if (flush) begin
            op_valid <= 1'b0;
        end else if (accept) begin
            op_valid <= 1'b1;
            op_a     <= reg_a;
            op_b     <= b_sel;
            op_cop   <= cop;
            op_data  <= data_reg;
            op_ldst  <= ldst_en;
            op_dest  <= dest_addr;
            op_we    <= we;
            op_bp    <= bp;
        end else if (out_load) begin
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            result      <= '0;
            ovf         <= 1'b0;
            data_reg_o  <= '0;
            ldst_en_o   <= '0;
            dest_addr_o <= '0;
            we_o        <= 1'b0;
            bp_o        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_valid   <= 1'b1;
            result      <= alu_res;
            ovf         <= alu_ovf;
            data_reg_o  <= op_data;
            ldst_en_o   <= op_ldst;
            dest_addr_o <= op_dest;
            we_o        <= op_we;
            bp_o        <= op_bp;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Set wins over clear so an overflow delivered alongside clr_ovf is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_sticky <= 1'b0;
        else        ovf_sticky <= (ovf_sticky && !clr_ovf) || (out_valid && out_ready && ovf && !flush);
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - randomized self-checking bench for alu_exec_stage with a reference model
module tb_alu_exec_stage;

    localparam int DW = 16;
    localparam int IW = 9;
    localparam int AW = 3;

    typedef struct {
        logic [DW-1:0] res;
        logic          ovf;
        logic [DW-1:0] dr;
        logic [1:0]    ls;
        logic [AW-1:0] da;
        logic          we;
        logic [1:0]    bp;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, clr_ovf = 1'b0, out_ready = 1'b1, we = 1'b0;
    logic [DW-1:0] reg_a = '0, reg_b = '0, data_reg = '0;
    logic [3:0]    cop = '0;
    logic [IW-1:0] imm = '0;
    logic [1:0]    ldst_en = '0, bp = '0;
    logic [AW-1:0] dest_addr = '0;

    logic in_ready, out_valid, ovf, ovf_sticky, we_o;
    logic [DW-1:0] result, data_reg_o;
    logic [1:0]    ldst_en_o, bp_o;
    logic [AW-1:0] dest_addr_o;

    logic s_in_ready, s_out_valid, s_ovf, s_ovf_sticky, s_we_o;
    logic [DW-1:0] s_result, s_data_reg_o;
    logic [1:0]    s_ldst_en_o, s_bp_o;
    logic [AW-1:0] s_dest_addr_o;

    int n_checks = 0, n_fail = 0, n_deliv = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic m_sticky = 1'b0, prev_stall = 1'b0, dlv, exp_ovf;
    logic [40:0] held;

    always #5 clk = ~clk;

    alu_exec_stage #(.DATA_W(DW), .IMM_W(IW), .RADDR_W(AW), .IMM_SIGNED(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .reg_a(reg_a), .reg_b(reg_b), .cop(cop), .imm(imm), .data_reg(data_reg),
        .ldst_en(ldst_en), .dest_addr(dest_addr), .we(we), .bp(bp),
        .flush(flush), .clr_ovf(clr_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .ovf_sticky(ovf_sticky), .data_reg_o(data_reg_o),
        .ldst_en_o(ldst_en_o), .dest_addr_o(dest_addr_o), .we_o(we_o), .bp_o(bp_o)
    );

    alu_exec_stage #(.DATA_W(DW), .IMM_W(IW), .RADDR_W(AW), .IMM_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .reg_a(reg_a), .reg_b(reg_b), .cop(cop), .imm(imm), .data_reg(data_reg),
        .ldst_en(ldst_en), .dest_addr(dest_addr), .we(we), .bp(bp),
        .flush(flush), .clr_ovf(clr_ovf), .out_valid(s_out_valid), .out_ready(out_ready),
        .result(s_result), .ovf(s_ovf), .ovf_sticky(s_ovf_sticky), .data_reg_o(s_data_reg_o),
        .ldst_en_o(s_ldst_en_o), .dest_addr_o(s_dest_addr_o), .we_o(s_we_o), .bp_o(s_bp_o)
    );

    wire [40:0] pack = {result, ovf, data_reg_o, ldst_en_o, dest_addr_o, we_o, bp_o};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] rb, input logic [IW-1:0] im,
                                          input bit sgn);
        longint ea, r, sa, sbv, ua, ub, lim;
        logic [DW-1:0] b;
        logic v;
        ea  = sgn ? longint'($signed(im)) : longint'(im);
        b   = (op == 4'd3 || op == 4'd6 || op == 4'd7) ? DW'(ea) : rb;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        lim = longint'(1) <<< (DW - 1);
        v = 1'b0;
        r = 0;
        case (op)
            4'd0, 4'd6, 4'd7: begin r = sa + sbv; v = (r >= lim) || (r < -lim); end
            4'd1:  begin r = sa - sbv; v = (r >= lim) || (r < -lim); end
            4'd2:  r = ua & ub;
            4'd3:  r = ub;
            4'd4:  r = ua | ub;
            4'd5:  r = ua ^ ub;
            4'd8:  r = ua << (ub % DW);
            4'd9:  r = ua >> (ub % DW);
            4'd10: begin r = ua * ub; v = r >= (longint'(1) <<< DW); end
            default: r = 0;
        endcase
        return {v, r[DW-1:0]};
    endfunction

    // Scoreboard: push on acceptance, pop and compare on delivery, track sticky and stall hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_sticky   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("sticky", ovf_sticky, m_sticky);
            if (prev_stall) check("hold", {out_valid, pack}, {1'b1, held});
            dlv = out_valid && out_ready && !flush;
            exp_ovf = 1'b0;
            if (dlv) begin
                if (sb.size() == 0) begin
                    check("spurious", 64'(sb.size()), 64'd1);
                end else begin
                    mon_e = sb.pop_front();
                    exp_ovf = mon_e.ovf;
                    n_deliv++;
                    check("result", result, mon_e.res);
                    check("ovf", ovf, mon_e.ovf);
                    check("sideband", {data_reg_o, ldst_en_o, dest_addr_o, we_o, bp_o},
                          {mon_e.dr, mon_e.ls, mon_e.da, mon_e.we, mon_e.bp});
                end
            end
            m_sticky   = (m_sticky && !clr_ovf) || (dlv && exp_ovf);
            prev_stall = out_valid && !out_ready && !flush;
            held       = pack;
            if (flush) sb.delete();
            if (in_valid && in_ready) begin
                {mon_e.ovf, mon_e.res} = model(cop, reg_a, reg_b, imm, 1'b0);
                mon_e.dr = data_reg;
                mon_e.ls = ldst_en;
                mon_e.da = dest_addr;
                mon_e.we = we;
                mon_e.bp = bp;
                sb.push_back(mon_e);
            end
        end
    end

    // Called just after a posedge; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [IW-1:0] im);
        bit ok = 0;
        cop = op; reg_a = a; reg_b = b; imm = im;
        data_reg = DW'($urandom); ldst_en = 2'($urandom); dest_addr = AW'($urandom);
        we = 1'($urandom); bp = 2'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) check("issue_timeout", in_ready, 1);
        else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int base, input int expect_n);
        out_ready = 1'b1;
        clr_ovf = 1'b0;
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check(tag, 64'(n_deliv - base), 64'(expect_n));
    endtask

    initial begin
        int bad_v, bad_r, base;
        bit drv_done;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sticky", ovf_sticky, 0);
        check("rst_outputs", pack, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(4'd0, 16'h7FFF, 16'h0001, '0);
        check("add_lat0", out_valid, 0);
        @(posedge clk); #1;
        check("add_lat1", out_valid, 1);
        check("add_res", result, 16'h8000);
        check("add_ovf", ovf, 1);
        @(posedge clk); #1;
        check("add_sticky", ovf_sticky, 1);

        issue(4'd3, 16'h1234, 16'h5678, 9'h1FF);
        @(posedge clk); #1;
        check("mov_zx", result, 16'h01FF);
        check("mov_sx", s_result, 16'hFFFF);
        issue(4'd6, 16'h0100, 16'hAAAA, 9'h004);
        @(posedge clk); #1;
        check("ld_addr", result, 16'h0104);

        issue(4'd10, 16'h0100, 16'h0100, '0);
        check("mul_rdy0", in_ready, 0);
        bad_v = 0; bad_r = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (out_valid) bad_v++;
            if (k <= 15 && in_ready) bad_r++;
        end
        check("mul_early_valid", 64'(bad_v), 0);
        check("mul_in_ready", 64'(bad_r), 0);
        @(posedge clk); #1;
        check("mul_lat", out_valid, 1);
        check("mul_res", result, 16'h0000);
        check("mul_ovf", ovf, 1);
        @(posedge clk); #1;

        base = n_deliv;
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(4'd0, DW'($urandom), DW'($urandom), '0);
                drv_done = 1;
            end
            begin
                for (int c = 0; c < 300 && !drv_done; c++) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        drain("stream_count", base, 8);

        base = n_deliv;
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 60; i++)
                    issue(4'($urandom_range(0, 15)), DW'($urandom), DW'($urandom), IW'($urandom));
                drv_done = 1;
            end
            begin
                for (int c = 0; c < 5000 && !drv_done; c++) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    clr_ovf   = ($urandom_range(0, 7) == 0);
                end
            end
        join
        drain("rand_count", base, 60);

        issue(4'd10, 16'h1234, 16'h0033, '0);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        bad_v = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) bad_v++;
        end
        check("flush_quiet", 64'(bad_v), 0);
        @(posedge clk); #1;
        issue(4'd0, 16'd2, 16'd3, '0);
        check("fl_add_lat0", out_valid, 0);
        @(posedge clk); #1;
        check("fl_add_lat1", out_valid, 1);
        check("fl_add_res", result, 16'd5);

        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(4'd0, 16'h7FFF, 16'h0001, '0);
        issue(4'd10, 16'h0003, 16'h0005, '0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_sticky", ovf_sticky, 0);
        check("arst_outputs", pack, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd0, 16'd2, 16'd3, '0);
        check("rel_lat0", out_valid, 0);
        @(posedge clk); #1;
        check("rel_lat1", out_valid, 1);
        check("rel_res", result, 16'd5);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
